// File: rtl/unified_mem_arbiter.sv
// rtl/unified_mem_arbiter.sv - single-port unified memory arbiter for IF fetch and MEM load/store
// Optional feature macro: ARB_PERF_CNT_EN (adds perf_clr, perf_if_wait, perf_d_wait)
module unified_mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  // instruction fetch port
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  output logic              if_stall,
  // load/store port
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_valid,
  output logic              d_stall,
  // memory side
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
`ifdef ARB_PERF_CNT_EN
  input  logic              perf_clr,
  output logic [31:0]       perf_if_wait,
  output logic [31:0]       perf_d_wait,
`endif
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_D} owner_t;

  localparam logic [3:0] LAT_INIT   = 4'(MEM_LAT - 1);
  localparam logic [3:0] STARVE_TOP = 4'(STARVE_MAX);

  state_t     state;
  state_t     state_nxt;
  owner_t     owner;
  logic       lat_we;
  logic [3:0] lat_cnt;
  logic [3:0] starve_cnt;
  logic       if_elig;
  logic       d_elig;
  logic       grant_if;
  logic       grant_d;

  // A requester whose valid is high this cycle drops req on the next edge,
  // so it is not eligible now; this equals its stall term.
  assign if_stall = if_req && !if_valid;
  assign d_stall  = d_req && !d_valid;
  assign if_elig  = if_stall;
  assign d_elig   = d_stall;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and grant decision; data wins unless IF has been starved
  always_comb begin
    state_nxt = state;
    grant_if  = 1'b0;
    grant_d   = 1'b0;
    case (state)
      IDLE: begin
        if (if_elig && (!d_elig || (starve_cnt == STARVE_TOP))) begin
          grant_if  = 1'b1;
          state_nxt = ISSUE;
        end else if (d_elig) begin
          grant_d   = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE:   state_nxt = lat_we ? DONE : WAIT;
      WAIT:    if (lat_cnt == 4'd0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Latch the winning request so later requester changes cannot disturb it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner     <= OWN_NONE;
      lat_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (grant_if) begin
      owner    <= OWN_IF;
      lat_we   <= 1'b0;
      mem_addr <= if_addr;
    end else if (grant_d) begin
      owner     <= OWN_D;
      lat_we    <= d_we;
      mem_addr  <= d_addr;
      mem_wdata <= d_wdata;
    end else if (state == DONE) begin
      owner <= OWN_NONE;
    end
  end

  // Access strobe: high only in the ISSUE cycle, so never back to back
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_en <= 1'b0;
      mem_we <= 1'b0;
    end else begin
      mem_en <= grant_if || grant_d;
      mem_we <= grant_d && d_we;
    end
  end

  // Read latency counter, loaded in ISSUE and counted down in WAIT
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lat_cnt <= 4'd0;
    end else if (state == ISSUE) begin
      lat_cnt <= LAT_INIT;
    end else if ((state == WAIT) && (lat_cnt != 4'd0)) begin
      lat_cnt <= lat_cnt - 4'd1;
    end
  end

  // Starvation counter: consecutive data grants that left a fetch waiting
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_cnt <= 4'd0;
    end else if (grant_if) begin
      starve_cnt <= 4'd0;
    end else if (grant_d) begin
      if (!if_req) begin
        starve_cnt <= 4'd0;
      end else if (starve_cnt != STARVE_TOP) begin
        starve_cnt <= starve_cnt + 4'd1;
      end
    end
  end

  // Read capture and completion pulses; a store acknowledges one cycle after DONE
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      if_rdata <= '0;
      d_rdata  <= '0;
      if_valid <= 1'b0;
      d_valid  <= 1'b0;
    end else begin
      if_valid <= 1'b0;
      d_valid  <= 1'b0;
      if ((state == WAIT) && (lat_cnt == 4'd0)) begin
        if (owner == OWN_IF) begin
          if_rdata <= mem_rdata;
          if_valid <= 1'b1;
        end else if (owner == OWN_D) begin
          d_rdata <= mem_rdata;
          d_valid <= 1'b1;
        end
      end
      if ((state == DONE) && (owner == OWN_D) && lat_we) begin
        d_valid <= 1'b1;
      end
    end
  end

`ifdef ARB_PERF_CNT_EN
  // Stall-cycle counters, saturating; perf_clr beats increment
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_if_wait <= 32'd0;
      perf_d_wait  <= 32'd0;
    end else if (perf_clr) begin
      perf_if_wait <= 32'd0;
      perf_d_wait  <= 32'd0;
    end else begin
      if (if_stall && (perf_if_wait != 32'hFFFF_FFFF)) perf_if_wait <= perf_if_wait + 32'd1;
      if (d_stall && (perf_d_wait != 32'hFFFF_FFFF)) perf_d_wait <= perf_d_wait + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb/tb_unified_mem_arbiter.sv - scoreboard bench for unified_mem_arbiter
module tb_unified_mem_arbiter;
  localparam int MEM_LAT    = 2;
  localparam int STARVE_MAX = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic [31:0] if_rdata;
  logic        if_valid, if_stall;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [31:0] d_rdata;
  logic        d_valid, d_stall;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;

  unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid), .if_stall(if_stall),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata),
    .d_valid(d_valid), .d_stall(d_stall),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  typedef struct { int cyc; logic [31:0] data; } rsp_t;
  typedef struct { int cyc; logic [31:0] addr; logic we; logic [31:0] wdata; } iss_t;
  typedef struct { int cyc; logic [31:0] addr; } rd_t;

  rsp_t if_q[$];
  rsp_t d_q[$];
  iss_t m_q[$];
  rd_t  rd_q[$];
  logic [31:0] mem_phys [logic [31:0]];
  logic [31:0] mem_ref  [logic [31:0]];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int if_mode = 0;
  int d_mode = 0;
  logic [31:0] if_shot_addr = '0;
  logic [31:0] d_shot_addr = '0;
  logic [31:0] d_shot_wdata = '0;
  logic        d_shot_we = 1'b0;
  logic        if_v_seen = 1'b0;
  logic        d_v_seen = 1'b0;
  logic        star_phase = 1'b0;
  int          star_ifs = 0;
  int          d_run = 0;

  function automatic logic [31:0] init_word(logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] rand_addr();
    return 32'($urandom_range(0, 63)) << 2;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h want %h", name, cyc, act, exp);
    end
  endtask

  initial forever #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end
  initial begin #300000; $display("FAIL watchdog expired"); $fatal(1, "watchdog"); end

  // valid seen in the cycle just ended, used by the requesters to drop req
  initial forever begin
    @(negedge clk);
    if_v_seen = if_valid;
    d_v_seen  = d_valid;
  end

  // fetch requester
  initial forever begin
    @(posedge clk); #1;
    if (if_req && if_v_seen) begin
      if (if_mode == 2 || (if_mode == 1 && $urandom_range(0, 1) == 0)) if_addr = rand_addr();
      else if_req = 1'b0;
    end else if (!if_req) begin
      if (if_mode == 3) begin
        if_req = 1'b1; if_addr = if_shot_addr; if_mode = 0;
      end else if (if_mode == 2 || (if_mode == 1 && $urandom_range(0, 3) == 0)) begin
        if_req = 1'b1; if_addr = rand_addr();
      end
    end
  end

  // load/store requester
  initial forever begin
    @(posedge clk); #1;
    if (d_req && d_v_seen) begin
      if (d_mode == 2) begin
        d_we = 1'b0; d_addr = rand_addr();
      end else if (d_mode == 1 && $urandom_range(0, 1) == 0) begin
        d_we = ($urandom_range(0, 2) == 0); d_addr = rand_addr(); d_wdata = $urandom;
      end else d_req = 1'b0;
    end else if (!d_req) begin
      if (d_mode == 3) begin
        d_req = 1'b1; d_we = d_shot_we; d_addr = d_shot_addr; d_wdata = d_shot_wdata; d_mode = 0;
      end else if (d_mode == 2) begin
        d_req = 1'b1; d_we = 1'b0; d_addr = rand_addr();
      end else if (d_mode == 1 && $urandom_range(0, 3) == 0) begin
        d_req = 1'b1; d_we = ($urandom_range(0, 2) == 0); d_addr = rand_addr(); d_wdata = $urandom;
      end
    end
  end

  // memory: accept strobes, return read data exactly MEM_LAT cycles later
  initial forever begin
    @(negedge clk);
    if (reset && mem_en) begin
      if (mem_we) mem_phys[mem_addr] = mem_wdata;
      else rd_q.push_back('{cyc: cyc + MEM_LAT, addr: mem_addr});
    end
  end

  initial begin : mem_drv
    rd_t q;
    forever begin
      @(posedge clk); #1;
      if (rd_q.size() > 0 && rd_q[0].cyc <= cyc) begin
        q = rd_q.pop_front();
        mem_rdata = mem_phys.exists(q.addr) ? mem_phys[q.addr] : init_word(q.addr);
      end else mem_rdata = $urandom;
    end
  end

  // transaction-level reference: who wins, when it issues, when it completes
  initial begin : model
    int free_at, if_vc, d_vc, starve, e;
    logic [31:0] d_last, data;
    logic if_e, d_e;
    free_at = 0; if_vc = -10; d_vc = -10; starve = 0; d_last = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        free_at = 0; if_vc = -10; d_vc = -10; starve = 0; d_last = '0;
      end else if (cyc >= free_at) begin
        if_e = if_req && (if_vc != cyc);
        d_e  = d_req && (d_vc != cyc);
        e = cyc + 1;
        if (if_e && (starve == STARVE_MAX || !d_e)) begin
          starve = 0;
          data = mem_ref.exists(if_addr) ? mem_ref[if_addr] : init_word(if_addr);
          if_vc = e + MEM_LAT + 1;
          free_at = e + MEM_LAT + 2;
          if_q.push_back('{cyc: if_vc, data: data});
          m_q.push_back('{cyc: e, addr: if_addr, we: 1'b0, wdata: '0});
        end else if (d_e) begin
          starve = if_req ? ((starve < STARVE_MAX) ? starve + 1 : STARVE_MAX) : 0;
          m_q.push_back('{cyc: e, addr: d_addr, we: d_we, wdata: d_wdata});
          if (d_we) begin
            mem_ref[d_addr] = d_wdata;
            d_vc = e + 2;
            free_at = e + 2;
          end else begin
            d_last = mem_ref.exists(d_addr) ? mem_ref[d_addr] : init_word(d_addr);
            d_vc = e + MEM_LAT + 1;
            free_at = e + MEM_LAT + 2;
          end
          d_q.push_back('{cyc: d_vc, data: d_last});
        end
      end
    end
  end

  // monitor: compare DUT outputs against the scoreboard queues
  initial begin : monitor
    rsp_t r;
    iss_t m;
    logic prev_en, if_now, d_now;
    prev_en = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) prev_en = 1'b0;
      else begin
        if_now = (if_q.size() > 0) && (if_q[0].cyc == cyc);
        d_now  = (d_q.size() > 0) && (d_q[0].cyc == cyc);
        chk("if_stall", if_stall, if_req && !if_now);
        chk("d_stall", d_stall, d_req && !d_now);
        if (if_valid) begin
          if (if_q.size() == 0) begin
            checks++; errors++; $display("FAIL if_valid unexpected at cycle %0d", cyc);
          end else begin
            r = if_q.pop_front();
            chk("if_valid_cycle", cyc, r.cyc);
            chk("if_rdata", if_rdata, r.data);
            if (star_phase) begin
              if (star_ifs > 0) chk("starve_run", d_run, STARVE_MAX);
              star_ifs++;
              d_run = 0;
            end
          end
        end else if (if_q.size() > 0 && if_q[0].cyc <= cyc) begin
          r = if_q.pop_front();
          checks++; errors++; $display("FAIL if_valid missing at cycle %0d, required at %0d", cyc, r.cyc);
        end
        if (d_valid) begin
          if (d_q.size() == 0) begin
            checks++; errors++; $display("FAIL d_valid unexpected at cycle %0d", cyc);
          end else begin
            r = d_q.pop_front();
            chk("d_valid_cycle", cyc, r.cyc);
            chk("d_rdata", d_rdata, r.data);
            if (star_phase) d_run++;
          end
        end else if (d_q.size() > 0 && d_q[0].cyc <= cyc) begin
          r = d_q.pop_front();
          checks++; errors++; $display("FAIL d_valid missing at cycle %0d, required at %0d", cyc, r.cyc);
        end
        if (mem_en) begin
          chk("mem_en_gap", prev_en, 1'b0);
          if (m_q.size() == 0) begin
            checks++; errors++; $display("FAIL mem_en unexpected at cycle %0d", cyc);
          end else begin
            m = m_q.pop_front();
            chk("mem_en_cycle", cyc, m.cyc);
            chk("mem_addr", mem_addr, m.addr);
            chk("mem_we", mem_we, m.we);
            if (m.we) chk("mem_wdata", mem_wdata, m.wdata);
          end
        end else if (m_q.size() > 0 && m_q[0].cyc <= cyc) begin
          m = m_q.pop_front();
          checks++; errors++; $display("FAIL mem_en missing at cycle %0d, required at %0d", cyc, m.cyc);
        end
        prev_en = mem_en;
      end
    end
  end

  task automatic chk_zero_outputs(string tag);
    chk({tag, "_mem_en"}, mem_en, 0);
    chk({tag, "_mem_we"}, mem_we, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
    chk({tag, "_if_valid"}, if_valid, 0);
    chk({tag, "_d_valid"}, d_valid, 0);
    chk({tag, "_if_rdata"}, if_rdata, 0);
    chk({tag, "_d_rdata"}, d_rdata, 0);
  endtask

  task automatic wait_idle(string name);
    int n;
    n = 0;
    @(posedge clk); #2;
    while ((if_q.size() > 0 || d_q.size() > 0 || m_q.size() > 0 || if_req || d_req) && n < 400) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 400) begin
      errors++;
      $display("FAIL %s timeout: queues if=%0d d=%0d mem=%0d still pending", name, if_q.size(), d_q.size(), m_q.size());
    end
  endtask

  initial begin : main
    int n;
    mem_phys[32'h10] = 32'h00A0_0093;
    mem_ref[32'h10]  = 32'h00A0_0093;
    repeat (3) @(posedge clk);
    #1;
    chk_zero_outputs("reset");

    // single fetch issued right at reset release
    @(negedge clk);
    if_shot_addr = 32'h10; if_mode = 3;
    @(posedge clk); #1;
    reset = 1'b1;
    wait_idle("single_fetch");

    // single store
    @(negedge clk);
    d_shot_we = 1'b1; d_shot_addr = 32'h100; d_shot_wdata = 32'hDEAD_BEEF; d_mode = 3;
    wait_idle("store");

    // simultaneous fetch and load
    @(negedge clk);
    if_shot_addr = 32'h20; d_shot_we = 1'b0; d_shot_addr = 32'h100; if_mode = 3; d_mode = 3;
    wait_idle("simultaneous");

    // random traffic
    @(negedge clk);
    if_mode = 1; d_mode = 1;
    repeat (400) @(posedge clk);
    @(negedge clk);
    if_mode = 0; d_mode = 0;
    wait_idle("random");

    // starvation: fetch held, loads re-issued back to back
    @(negedge clk);
    star_ifs = 0; d_run = 0; star_phase = 1'b1; if_mode = 2; d_mode = 2;
    repeat (120) @(posedge clk);
    @(negedge clk);
    star_phase = 1'b0; if_mode = 0; d_mode = 0;
    wait_idle("starvation");
    chk("starve_if_grants_seen", star_ifs >= 3, 1);

    // reset during the WAIT of a load
    @(negedge clk);
    d_shot_we = 1'b0; d_shot_addr = 32'h100; d_mode = 3;
    n = 0;
    do begin @(negedge clk); n++; end while (!(mem_en && !mem_we) && n < 20);
    chk("rst_load_issued", n < 20, 1);
    @(posedge clk); #3;
    reset = 1'b0;
    if_q.delete(); d_q.delete(); m_q.delete(); rd_q.delete();
    #1;
    chk_zero_outputs("async_reset");
    repeat (2) @(posedge clk);
    #1;
    chk("held_reset_d_valid", d_valid, 0);
    reset = 1'b1;
    wait_idle("reset_reissue");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
